// File: rtl/tracklet_calculator_pkg.sv
// Shared widths and FSM encoding for the tracklet calculator signed divider.
// Defaults give a 30-bit signed dividend, 15-bit signed divisor and 16-bit signed quotient.
`timescale 1ns/1ps
package tracklet_calculator_pkg;

  localparam int TC_DIVIDEND_W = 30;
  localparam int TC_DIVISOR_W  = 15;
  localparam int TC_QUOTIENT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tracklet_calculator_sdiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, emit quotient bit.
// Purely combinational; the caller registers the partial remainder and the dividend/quotient shifter.
`timescale 1ns/1ps
module tracklet_calculator_sdiv_step
  import tracklet_calculator_pkg::*;
#(
  parameter int DIVISOR_W  = TC_DIVISOR_W,
  parameter int QUOTIENT_W = TC_QUOTIENT_W
) (
  input  logic [DIVISOR_W-1:0]  part_i,
  input  logic [QUOTIENT_W-1:0] dq_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic [DIVISOR_W-1:0]  part_o,
  output logic [QUOTIENT_W-1:0] dq_o
);

  logic [DIVISOR_W:0] trial;
  logic               fits;

  // part_i < divisor_i always holds, so the shifted trial fits in DIVISOR_W+1 bits
  // and the restored remainder fits back in DIVISOR_W bits.
  always_comb begin
    trial  = {part_i, dq_i[QUOTIENT_W-1]};
    fits   = (trial >= {1'b0, divisor_i});
    part_o = fits ? (trial[DIVISOR_W-1:0] - divisor_i) : trial[DIVISOR_W-1:0];
    dq_o   = {dq_i[QUOTIENT_W-2:0], fits};
  end

endmodule

// File: rtl/tracklet_calculator_sdiv_30s_15s_16.sv
// Signed truncating divider, one quotient bit per cycle; result QUOTIENT_W+1 cycles after capture,
// held in DONE until out_ready. TC_SDIV_REMAINDER_EN adds the signed remainder output rem.
`timescale 1ns/1ps
module tracklet_calculator_sdiv_30s_15s_16
  import tracklet_calculator_pkg::*;
#(
  parameter int DIVIDEND_W = TC_DIVIDEND_W,
  parameter int DIVISOR_W  = TC_DIVISOR_W,
  parameter int QUOTIENT_W = TC_QUOTIENT_W
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic signed [DIVISOR_W-1:0]  din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOTIENT_W-1:0] dout,
  output logic                         div_zero,
  output logic                         ovf
`ifdef TC_SDIV_REMAINDER_EN
  ,
  output logic signed [DIVISOR_W-1:0]  rem
`endif
);

  localparam int CNT_W = $clog2(QUOTIENT_W + 1);
  localparam int CMP_W = (DIVIDEND_W > DIVISOR_W + QUOTIENT_W) ? DIVIDEND_W : DIVISOR_W + QUOTIENT_W;
  localparam logic [QUOTIENT_W-1:0] Q_MAX_POS = {1'b0, {(QUOTIENT_W-1){1'b1}}};
  localparam logic [QUOTIENT_W-1:0] Q_MAX_NEG = {1'b1, {(QUOTIENT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(QUOTIENT_W);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;

  logic [DIVISOR_W-1:0]  b_mag_q, b_mag_d;
  logic [DIVISOR_W-1:0]  part_q, part_d;
  logic [QUOTIENT_W-1:0] dq_q, dq_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic                  a_neg_q, a_neg_d;
  logic                  dz_q, dz_d;
  logic                  ovf_cap_q, ovf_cap_d;
  logic [QUOTIENT_W-1:0] dout_q, dout_d;
  logic                  div_zero_q, div_zero_d;
  logic                  ovf_q, ovf_d;
`ifdef TC_SDIV_REMAINDER_EN
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
`endif

  logic                  take;
  logic                  last_step;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [CMP_W-1:0]      a_ext;
  logic [CMP_W-1:0]      b_shift;
  logic [DIVISOR_W-1:0]  step_part;
  logic [QUOTIENT_W-1:0] step_dq;
  logic                  q_ovf;
  logic [QUOTIENT_W-1:0] q_sat;

  assign take      = in_valid && in_ready_q && (state_q == IDLE);
  assign last_step = (cnt_q == CNT_LAST);
  assign a_mag     = din0[DIVIDEND_W-1] ? DIVIDEND_W'(-din0) : DIVIDEND_W'(din0);
  assign b_mag     = din1[DIVISOR_W-1]  ? DIVISOR_W'(-din1)  : DIVISOR_W'(din1);
  assign a_ext     = CMP_W'(a_mag);
  assign b_shift   = CMP_W'(b_mag) << QUOTIENT_W;

  // The negative side can reach one count further than the positive side.
  assign q_ovf = sign_q ? (dq_q > Q_MAX_NEG) : (dq_q > Q_MAX_POS);
  assign q_sat = sign_q ? Q_MAX_NEG : Q_MAX_POS;

  tracklet_calculator_sdiv_step #(
    .DIVISOR_W  (DIVISOR_W),
    .QUOTIENT_W (QUOTIENT_W)
  ) u_step (
    .part_i    (part_q),
    .dq_i      (dq_q),
    .divisor_i (b_mag_q),
    .part_o    (step_part),
    .dq_o      (step_dq)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = CALC;
      CALC:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = (state_q == DONE);
    dout      = dout_q;
    div_zero  = div_zero_q;
    ovf       = ovf_q;
`ifdef TC_SDIV_REMAINDER_EN
    rem       = rem_q;
`endif
  end

  always_comb begin
    b_mag_d    = b_mag_q;
    part_d     = part_q;
    dq_d       = dq_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    a_neg_d    = a_neg_q;
    dz_d       = dz_q;
    ovf_cap_d  = ovf_cap_q;
    dout_d     = dout_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
`ifdef TC_SDIV_REMAINDER_EN
    rem_d      = rem_q;
`endif
    if (take) begin
      // Upper dividend bits seed the partial remainder; when no overflow they are below the divisor.
      b_mag_d   = b_mag;
      a_neg_d   = din0[DIVIDEND_W-1];
      sign_d    = din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
      dz_d      = (din1 == '0);
      ovf_cap_d = (a_ext >= b_shift);
      part_d    = DIVISOR_W'(a_mag >> QUOTIENT_W);
      dq_d      = QUOTIENT_W'(a_mag);
      cnt_d     = '0;
    end else if (state_q == CALC) begin
      if (!last_step) begin
        part_d = step_part;
        dq_d   = step_dq;
        cnt_d  = cnt_q + CNT_W'(1);
      end else if (dz_q) begin
        dout_d     = a_neg_q ? Q_MAX_NEG : Q_MAX_POS;
        div_zero_d = 1'b1;
        ovf_d      = 1'b0;
`ifdef TC_SDIV_REMAINDER_EN
        rem_d      = '0;
`endif
      end else if (ovf_cap_q || q_ovf) begin
        dout_d     = q_sat;
        div_zero_d = 1'b0;
        ovf_d      = 1'b1;
`ifdef TC_SDIV_REMAINDER_EN
        rem_d      = '0;
`endif
      end else begin
        dout_d     = sign_q ? (-dq_q) : dq_q;
        div_zero_d = 1'b0;
        ovf_d      = 1'b0;
`ifdef TC_SDIV_REMAINDER_EN
        rem_d      = a_neg_q ? (-part_q) : part_q;
`endif
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      in_ready_q <= 1'b0;
      b_mag_q    <= '0;
      part_q     <= '0;
      dq_q       <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_cap_q  <= 1'b0;
      dout_q     <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef TC_SDIV_REMAINDER_EN
      rem_q      <= '0;
`endif
    end else begin
      in_ready_q <= in_ready_d;
      b_mag_q    <= b_mag_d;
      part_q     <= part_d;
      dq_q       <= dq_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      a_neg_q    <= a_neg_d;
      dz_q       <= dz_d;
      ovf_cap_q  <= ovf_cap_d;
      dout_q     <= dout_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
`ifdef TC_SDIV_REMAINDER_EN
      rem_q      <= rem_d;
`endif
    end
  end

endmodule
